// File: rtl/fec_pkg.sv
// fec_pkg: shared constants, encoder FSM state type and generator-tap parity helper
package fec_pkg;
    localparam int BLOCK_BITS = 96;
    localparam int CODED_BITS = 192;
    localparam int CC_K = 7;
    localparam logic [CC_K-1:0] CC_G1 = 7'o171;
    localparam logic [CC_K-1:0] CC_G2 = 7'o133;

    typedef enum logic {LOAD, ENCODE} fec_enc_state_t;

    // generators are read MSB-first as {u, s0, s1, ..., s5}
    function automatic logic cc_parity(input logic [CC_K-1:0] g, input logic u, input logic [CC_K-2:0] s);
        logic [CC_K-1:0] taps;
        taps[CC_K-1] = u;
        for (int i = 0; i < CC_K-1; i++) taps[CC_K-2-i] = s[i];
        return ^(taps & g);
    endfunction
endpackage

// File: rtl/fec_cc_encoder_if.sv
// fec_cc_encoder_if: serial input and coded-output handshake bundle of the encoder
interface fec_cc_encoder_if;
    logic data_in, valid_in, ready_in;
    logic data_out, valid_out, ready_out;
    modport master(output data_in, valid_in, ready_out, input ready_in, data_out, valid_out);
    modport slave(input data_in, valid_in, ready_out, output ready_in, data_out, valid_out);
endinterface

// File: rtl/fec_cc_core.sv
// fec_cc_core: K=7 convolutional shift register with X/Y generator outputs
module fec_cc_core import fec_pkg::*; (
    input  logic            clk,
    input  logic            resetN,
    input  logic            init,
    input  logic [CC_K-2:0] init_value,
    input  logic            shift,
    input  logic            u,
    output logic            x,
    output logic            y
);
    logic [CC_K-2:0] s;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) s <= '0;
        else if (init) s <= init_value;
        else if (shift) s <= {s[CC_K-3:0], u};

    assign x = cc_parity(CC_G1, u, s);
    assign y = cc_parity(CC_G2, u, s);
endmodule

// File: rtl/fec_cc_encoder.sv
// fec_cc_encoder: rate-1/2 K=7 tail-biting convolutional encoder over 96-bit blocks.
// Define FEC_BLKCNT_EN to add the blk_count completed-block counter port.
module fec_cc_encoder import fec_pkg::*; (
    input  logic              clk,
    input  logic              resetN,
    fec_cc_encoder_if.slave   bus
`ifdef FEC_BLKCNT_EN
    ,
    output logic [15:0]       blk_count
`endif
);
    fec_enc_state_t state, state_next;
    logic [BLOCK_BITS-1:0] buffer;
    logic [6:0] idx;
    logic phase, accept, advance, last, init, shift, u, x, y;
    logic [CC_K-2:0] init_value;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) state <= LOAD;
        else state <= state_next;

    always_comb begin
        state_next = state;
        bus.ready_in = (state == LOAD);
        bus.valid_out = (state == ENCODE);
        accept = bus.ready_in && bus.valid_in;
        advance = bus.valid_out && bus.ready_out;
        last = (idx == 7'(BLOCK_BITS-1));
        init = accept && last;
        shift = advance && phase;
        if (init) state_next = ENCODE;
        if (shift && last) state_next = LOAD;
        u = buffer[idx];
        bus.data_out = bus.valid_out && (phase ? y : x);
    end

    // tail-biting start: the last six inputs preload the register, b95 arriving this cycle
    assign init_value = {buffer[BLOCK_BITS-6], buffer[BLOCK_BITS-5], buffer[BLOCK_BITS-4],
                         buffer[BLOCK_BITS-3], buffer[BLOCK_BITS-2], bus.data_in};

    always_ff @(posedge clk)
        if (accept) buffer[idx] <= bus.data_in;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            idx <= '0;
            phase <= 1'b0;
        end else if (accept) begin
            idx <= last ? '0 : idx + 7'd1;
        end else if (advance) begin
            phase <= !phase;
            if (phase) idx <= last ? '0 : idx + 7'd1;
        end

`ifdef FEC_BLKCNT_EN
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) blk_count <= '0;
        else if (shift && last) blk_count <= blk_count + 16'd1;
`endif

    fec_cc_core u_core (
        .clk        (clk),
        .resetN     (resetN),
        .init       (init),
        .init_value (init_value),
        .shift      (shift),
        .u          (u),
        .x          (x),
        .y          (y)
    );
endmodule

// File: tb/tb_fec_cc_encoder.sv
// tb_fec_cc_encoder: directed and randomized blocks checked against a tail-biting reference model
module tb_fec_cc_encoder;
    import fec_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int tests = 0;
    int fails = 0;
    logic blk [BLOCK_BITS];
    logic ref_bits [CODED_BITS];

    fec_cc_encoder_if bus();
`ifdef FEC_BLKCNT_EN
    logic [15:0] blk_count;
    logic [15:0] exp_count = '0;
`endif

    fec_cc_encoder dut (
        .clk       (clk),
        .resetN    (resetN),
        .bus       (bus)
`ifdef FEC_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // coded pair i depends on b[i-d], d=0..6, indices taken modulo the block length
    function automatic void build_ref();
        for (int i = 0; i < BLOCK_BITS; i++) begin
            logic [6:0] w;
            for (int d = 0; d < 7; d++) w[d] = blk[(i - d + BLOCK_BITS) % BLOCK_BITS];
            ref_bits[2*i]   = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[6];
            ref_bits[2*i+1] = w[0] ^ w[2] ^ w[3] ^ w[5] ^ w[6];
        end
    endfunction

    function automatic void fill_blk(input int mode);
        for (int i = 0; i < BLOCK_BITS; i++)
            blk[i] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? (i == 0) :
                     (mode == 3) ? (i == BLOCK_BITS-1) : 1'($urandom);
    endfunction

    task automatic load_bits(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.valid_in = 1'b0;
                bus.data_in = 1'($urandom);
                check1("idle_ready_in", bus.ready_in, 1'b1);
            end
            @(negedge clk);
            check1("load_valid_out", bus.valid_out, 1'b0);
            check1("load_data_out", bus.data_out, 1'b0);
            bus.valid_in = 1'b1;
            bus.data_in = blk[i];
        end
    endtask

    task automatic collect(input int n, input bit rnd);
        int k = 0;
        for (int cyc = 0; k < n && cyc < 4000; cyc++) begin
            @(negedge clk);
            bus.valid_in = 1'($urandom);
            bus.data_in = 1'($urandom);
            bus.ready_out = rnd ? 1'($urandom) : 1'b1;
            check1("enc_valid_out", bus.valid_out, 1'b1);
            check1("enc_ready_in", bus.ready_in, 1'b0);
            if (bus.ready_out) begin
                check1($sformatf("coded_bit_%0d", k), bus.data_out, ref_bits[k]);
                k++;
            end
        end
        if (k < n) check16("collect_timeout", 16'(k), 16'(n));
    endtask

    task automatic end_check();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.ready_out = 1'b0;
        check1("end_ready_in", bus.ready_in, 1'b1);
        check1("end_valid_out", bus.valid_out, 1'b0);
        check1("end_data_out", bus.data_out, 1'b0);
`ifdef FEC_BLKCNT_EN
        exp_count++;
        check16("blk_count", blk_count, exp_count);
`endif
    endtask

    task automatic run_block(input bit rnd);
        load_bits(BLOCK_BITS);
        collect(CODED_BITS, rnd);
        end_check();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.ready_out = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check1("rst_valid_out", bus.valid_out, 1'b0);
        check1("rst_data_out", bus.data_out, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
`ifdef FEC_BLKCNT_EN
        exp_count = '0;
        check16("rst_blk_count", blk_count, exp_count);
`endif
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            bus.ready_out = 1'($urandom);
            check1("idle_valid_out", bus.valid_out, 1'b0);
            check1("idle_data_out", bus.data_out, 1'b0);
            check1("idle_ready_in", bus.ready_in, 1'b1);
        end
    endtask

    initial begin
        bus.data_in = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_out = 1'b0;
        #12;
        check1("reset_valid_out", bus.valid_out, 1'b0);
        check1("reset_data_out", bus.data_out, 1'b0);
`ifdef FEC_BLKCNT_EN
        check16("reset_blk_count", blk_count, 16'd0);
`endif
        @(negedge clk);
        resetN = 1'b1;
        idle_check(2);

        fill_blk(0);
        for (int i = 0; i < CODED_BITS; i++) ref_bits[i] = 1'b0;
        run_block(1'b0);

        fill_blk(1);
        for (int i = 0; i < CODED_BITS; i++) ref_bits[i] = 1'b1;
        run_block(1'b0);

        // impulse at b0: known 14-bit response, then silence
        fill_blk(2);
        for (int i = 0; i < CODED_BITS; i++) ref_bits[i] = (i < 14) ? 1'(14'b11101111000111 >> (13 - i)) : 1'b0;
        run_block(1'b0);
        run_block(1'b1);

        // impulse at b95 wraps around through the tail-biting start state
        fill_blk(3);
        for (int i = 0; i < CODED_BITS; i++) ref_bits[i] = (i < 12) ? 1'(12'b101111000111 >> (11 - i)) : (i >= 190);
        run_block(1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_blk(4);
            build_ref();
            run_block(r[0]);
        end

        fill_blk(4);
        load_bits(50);
        pulse_reset();
        idle_check(10);
        fill_blk(4);
        build_ref();
        load_bits(BLOCK_BITS);
        collect(100, 1'b1);
        pulse_reset();
        idle_check(10);
        fill_blk(4);
        build_ref();
        run_block(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
